// File: rtl/led_shift_driver.sv
// Serialises an LED vector MSB first into a 74HC595-style shift/latch register, then pulses the latch.
// Latency: a frame starts on the first edge that sees a new vector; busy lasts 2*CLK_DIV*WIDTH+CLK_DIV cycles.
// Backpressure: none; input changes during a frame are ignored and the newest value is sent once idle.
//
// Ports:
//   _i_clk    system clock, rising edge
//   _i_rst    synchronous active-high reset
//   _i_leds   LED vector to display
//   _o_sclk   shift clock to the external register
//   _o_sdata  serial data, stable while _o_sclk is high
//   _o_latch  storage-register latch pulse, active high
//   _o_busy   high while a frame (shift + latch) is in progress
module led_shift_driver #(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 4
) (
    input  logic             _i_clk,
    input  logic             _i_rst,
    input  logic [WIDTH-1:0] _i_leds,
    output logic             _o_sclk,
    output logic             _o_sdata,
    output logic             _o_latch,
    output logic             _o_busy
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shadow;   // frame being sent, frozen for the whole frame
    logic [WIDTH-1:0] sent;     // last value that reached the storage register
    logic             dirty;    // forces one frame after reset even if the vector matches sent
    logic [BW-1:0]    bit_idx;
    logic [DW-1:0]    div_cnt;
    logic             div_done;

    assign div_done = (div_cnt == DW'(CLK_DIV - 1));

    always_ff @(posedge _i_clk) begin
        if (_i_rst) begin
            state    <= IDLE;
            shadow   <= '0;
            sent     <= '0;
            dirty    <= 1'b1;
            bit_idx  <= '0;
            div_cnt  <= '0;
            _o_sclk  <= 1'b0;
            _o_sdata <= 1'b0;
            _o_latch <= 1'b0;
            _o_busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    if (dirty || (_i_leds != sent)) begin
                        shadow   <= _i_leds;
                        bit_idx  <= BW'(WIDTH - 1);
                        _o_busy  <= 1'b1;
                        // First data bit is presented together with busy, ahead of the first sclk rise.
                        _o_sdata <= _i_leds[WIDTH-1];
                        _o_sclk  <= 1'b0;
                        _o_latch <= 1'b0;
                        state    <= SHIFT_LO;
                    end else begin
                        _o_busy  <= 1'b0;
                        _o_sdata <= 1'b0;
                        _o_sclk  <= 1'b0;
                        _o_latch <= 1'b0;
                    end
                end

                SHIFT_LO: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        _o_sclk <= 1'b1;
                        state   <= SHIFT_HI;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                SHIFT_HI: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        _o_sclk <= 1'b0;
                        // Data only moves on the sclk falling-edge cycle, so it is stable while sclk is high.
                        if (bit_idx != '0) begin
                            bit_idx  <= bit_idx - 1'b1;
                            _o_sdata <= shadow[bit_idx - 1'b1];
                            state    <= SHIFT_LO;
                        end else begin
                            _o_sdata <= 1'b0;
                            _o_latch <= 1'b1;
                            state    <= LATCH;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                LATCH: begin
                    if (div_done) begin
                        div_cnt  <= '0;
                        _o_latch <= 1'b0;
                        _o_busy  <= 1'b0;
                        sent     <= shadow;
                        dirty    <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_shift_driver.sv
// Scoreboard bench for led_shift_driver with a behavioural 595 model on the serial pins.
// Latency: expected frames are queued by the stimulus and popped by the monitor when busy falls.
// Backpressure: none; every wait is bounded by a cycle budget.
module tb_led_shift_driver;

    localparam int W     = 8;
    localparam int CD    = 2;
    localparam int FRAME = 2 * CD * W + CD;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] leds = '0;
    logic         sclk, sdata, latch, busy;

    always #5 clk = ~clk;

    led_shift_driver #(.WIDTH(W), .CLK_DIV(CD)) dut (
        ._i_clk  (clk),
        ._i_rst  (rst),
        ._i_leds (leds),
        ._o_sclk (sclk),
        ._o_sdata(sdata),
        ._o_latch(latch),
        ._o_busy (busy)
    );

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // 595 model and frame measurement
    logic [W-1:0] shift_reg = '0;
    logic [W-1:0] storage   = '0;
    int           rises     = 0;
    int           busy_len  = 0;
    int           latch_len = 0;
    int           gap       = 0;
    bit           frame_on  = 0;
    bit           check_gap = 0;
    logic         prev_sclk = 0, prev_sdata = 0, prev_latch = 0, prev_busy = 0;
    logic         rst_q = 0;

    always @(posedge clk) rst_q <= rst;

    always @(negedge clk) begin
        if (rst_q) begin
            check("reset_outputs", {28'd0, sclk, sdata, latch, busy}, 32'd0);
            frame_on  = 0;
            rises     = 0;
            busy_len  = 0;
            latch_len = 0;
            gap       = 0;
        end else begin
            if (sclk && !prev_sclk) begin
                shift_reg = {shift_reg[W-2:0], sdata};
                rises++;
            end
            if (sclk && prev_sclk)
                check("sdata_stable_sclk_high", {31'd0, sdata}, {31'd0, prev_sdata});
            if (latch && !prev_latch)
                storage = shift_reg;
            if (latch)
                latch_len++;
            if (busy && !prev_busy) begin
                frame_on  = 1;
                busy_len  = 0;
                latch_len = 0;
                rises     = 0;
                if (check_gap) begin
                    check("busy_gap", gap, 1);
                    check_gap = 0;
                end
            end
            if (!busy && prev_busy && frame_on) begin
                frame_on = 0;
                gap      = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: latched 0x%0h, expected no frame", storage);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    check("latched_value", storage, e);
                    check("busy_cycles", busy_len, FRAME);
                    check("sclk_rises", rises, W);
                    check("latch_cycles", latch_len, CD);
                end
            end
            if (busy) busy_len++;
            else      gap++;
        end
        prev_sclk  = sclk;
        prev_sdata = sdata;
        prev_latch = latch;
        prev_busy  = busy;
    end

    task automatic wait_done(input string name, input int budget);
        int idle = 0;
        for (int c = 0; c < budget && idle < 3; c++) begin
            @(negedge clk);
            idle = (exp_q.size() == 0 && !busy && !frame_on) ? idle + 1 : 0;
        end
        if (idle < 3) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, %0d frames still pending, required 0", name, exp_q.size());
        end
    endtask

    task automatic wait_rises(input string name, input int n);
        int c = 0;
        while (!(frame_on && rises >= n) && c < 500) begin
            @(negedge clk);
            c++;
        end
        if (c >= 500) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout waiting for sclk rise %0d, saw %0d", name, n, rises);
        end
    endtask

    initial begin
        // 1: reset with 0x00, then one frame of 0x00
        rst  = 1'b1;
        leds = 8'h00;
        repeat (10) @(posedge clk);
        #1;
        exp_q.push_back(8'h00);
        rst = 1'b0;
        wait_done("t1_post_reset_frame", 300);

        // 2: 0xA5 shifted MSB first
        @(posedge clk); #1;
        leds = 8'hA5;
        exp_q.push_back(8'hA5);
        wait_done("t2_a5", 300);

        // 3: change during a frame is deferred to a back-to-back frame
        @(posedge clk); #1;
        leds = 8'h01;
        exp_q.push_back(8'h01);
        wait_rises("t3_third_rise", 3);
        @(posedge clk); #1;
        leds = 8'h80;
        exp_q.push_back(8'h80);
        check_gap = 1;
        wait_done("t3_b2b", 400);

        // 4: unchanged vector produces no activity
        begin
            logic act = 1'b0;
            repeat (200) begin
                @(negedge clk);
                act = act | busy | sclk | latch;
            end
            check("t4_idle_quiet", {31'd0, act}, 32'd0);
        end

        // 5: reset mid-frame aborts without latching, then a full frame follows
        @(posedge clk); #1;
        leds = 8'h3C;
        exp_q.push_back(8'h3C);
        wait_rises("t5_fifth_rise", 5);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t5_storage_held", storage, 8'h80);
        wait_done("t5_after_reset", 300);

        // 6: bouncing single-bit source stepping every 3 cycles
        begin
            int   pos = 0, dir = 1, tick = 0;
            logic last_busy = 1'b0;
            logic [W-1:0] one = 1;
            for (int c = 0; c < 550; c++) begin
                @(posedge clk); #1;
                // The value sampled at the edge that raised busy is still on leds here.
                if (busy && !last_busy)
                    exp_q.push_back(leds);
                last_busy = busy;
                if (c < 400) begin
                    tick++;
                    if (tick == 3) begin
                        tick = 0;
                        if (pos == W - 1) dir = -1;
                        else if (pos == 0) dir = 1;
                        pos  = pos + dir;
                        leds = one << pos;
                    end
                end
            end
            wait_done("t6_chain", 300);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
